pdm_frame_ctrl: RTL and testbench

PDM_FRAME_CTRL -- requirements
Module: pdm_frame_ctrl

---
 rtl/pdm_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pdm_frame_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pdm_frame_ctrl.sv
// PDM microphone front end: sclk generation, ones-count decimation, frame
// hand-off to an external decode engine and class indication (leds/beep).
module pdm_frame_ctrl #(
  parameter int unsigned CLK_DIV  = 12,
  parameter int unsigned DEC      = 64,
  parameter int unsigned FRAME    = 256,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned BEEP_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dat_i,
  output logic                 sclk,
  output logic                 smp_valid,
  output logic [$clog2(DEC):0] smp_data,
  output logic                 frm_last,
  output logic                 eng_start,
  input  logic                 eng_done,
  input  logic [1:0]           eng_result,
  output logic                 led1,
  output logic                 led2,
  output logic                 led3,
  output logic                 beep,
  output logic                 timeout
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W  = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int unsigned SMP_W  = $clog2(DEC) + 1;
  localparam int unsigned FRM_W  = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned BEEP_W = $clog2(BEEP_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DECODE,
    ST_REPORT
  } state_e;

  state_e              state_q;
  logic [DIV_W-1:0]    div_q;
  logic                sclk_q;
  logic [BIT_W-1:0]    bit_q;
  logic [SMP_W-1:0]    acc_q;
  logic [SMP_W-1:0]    acc_d;
  logic [FRM_W-1:0]    smp_cnt_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [1:0]          cls_q;
  logic [BEEP_W-1:0]   beep_cnt_q;
  logic [BEEP_W-1:0]   beep_cnt_d;
  logic                smp_valid_q;
  logic [SMP_W-1:0]    smp_data_q;
  logic                frm_last_q;
  logic                eng_start_q;
  logic [2:0]          led_q;
  logic                beep_q;
  logic                timeout_q;
  logic                div_wrap;
  logic                fall;
  logic                win_done;

  // Bit-clock timing, window completion and beep countdown.
  always_comb begin
    div_wrap   = (div_q == DIV_W'(CLK_DIV - 1));
    fall       = div_wrap && sclk_q;
    win_done   = fall && (bit_q == BIT_W'(DEC - 1));
    acc_d      = acc_q + SMP_W'(dat_i);
    beep_cnt_d = beep_cnt_q;
    if (state_q == ST_REPORT && cls_q == 2'd3) begin
      beep_cnt_d = BEEP_W'(BEEP_CYC);
    end else if (beep_cnt_q != '0) begin
      beep_cnt_d = beep_cnt_q - BEEP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      sclk_q      <= 1'b0;
      bit_q       <= '0;
      acc_q       <= '0;
      smp_cnt_q   <= '0;
      wait_q      <= '0;
      cls_q       <= '0;
      beep_cnt_q  <= '0;
      smp_valid_q <= 1'b0;
      smp_data_q  <= '0;
      frm_last_q  <= 1'b0;
      eng_start_q <= 1'b0;
      led_q       <= '0;
      beep_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
      if (div_wrap) begin
        sclk_q <= ~sclk_q;
      end

      // Data is taken on the sclk falling edge; windows run back to back.
      if (fall) begin
        if (win_done) begin
          bit_q      <= '0;
          acc_q      <= '0;
          smp_data_q <= acc_d;
        end else begin
          bit_q <= bit_q + BIT_W'(1);
          acc_q <= acc_d;
        end
      end

      beep_cnt_q  <= beep_cnt_d;
      beep_q      <= (beep_cnt_d != '0);
      smp_valid_q <= 1'b0;
      frm_last_q  <= 1'b0;
      eng_start_q <= 1'b0;

      unique case (state_q)
        // Wait for an untouched window so every frame starts on a full sample.
        ST_IDLE: begin
          if (bit_q == '0) begin
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (win_done) begin
            smp_valid_q <= 1'b1;
            if (smp_cnt_q == FRM_W'(FRAME - 1)) begin
              frm_last_q  <= 1'b1;
              eng_start_q <= 1'b1;
              smp_cnt_q   <= '0;
              wait_q      <= '0;
              state_q     <= ST_DECODE;
            end else begin
              smp_cnt_q <= smp_cnt_q + FRM_W'(1);
            end
          end
        end
        // eng_done is checked first so it wins over a coincident timeout.
        ST_DECODE: begin
          if (eng_done) begin
            cls_q   <= eng_result;
            state_q <= ST_REPORT;
          end else if (win_done) begin
            if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
              timeout_q <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              wait_q <= wait_q + WAIT_W'(1);
            end
          end
        end
        ST_REPORT: begin
          led_q[0] <= (cls_q == 2'd1);
          led_q[1] <= (cls_q == 2'd2);
          led_q[2] <= (cls_q == 2'd3);
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sclk      = sclk_q;
  assign smp_valid = smp_valid_q;
  assign smp_data  = smp_data_q;
  assign frm_last  = frm_last_q;
  assign eng_start = eng_start_q;
  assign led1      = led_q[0];
  assign led2      = led_q[1];
  assign led3      = led_q[2];
  assign beep      = beep_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_pdm_frame_ctrl.sv
// Randomized bench for pdm_frame_ctrl: a window/frame-level reference model
// predicts every output each cycle; engine replies are scripted per frame.
module tb_pdm_frame_ctrl;

  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned DEC      = 8;
  localparam int unsigned FRAME    = 6;
  localparam int unsigned TIMEOUT  = 5;
  localparam int unsigned BEEP_CYC = 300;
  localparam int unsigned P        = 2 * CLK_DIV;
  localparam int unsigned W        = P * DEC;
  localparam int unsigned SW       = $clog2(DEC) + 1;
  localparam int unsigned NCYC     = 7000;

  logic          clk = 1'b0;
  logic          rst;
  logic          dat_i;
  logic          sclk;
  logic          smp_valid;
  logic [SW-1:0] smp_data;
  logic          frm_last;
  logic          eng_start;
  logic          eng_done;
  logic [1:0]    eng_result;
  logic          led1;
  logic          led2;
  logic          led3;
  logic          beep;
  logic          timeout;

  always #5 clk = ~clk;

  pdm_frame_ctrl #(
    .CLK_DIV (CLK_DIV),
    .DEC     (DEC),
    .FRAME   (FRAME),
    .TIMEOUT (TIMEOUT),
    .BEEP_CYC(BEEP_CYC)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .dat_i     (dat_i),
    .sclk      (sclk),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .frm_last  (frm_last),
    .eng_start (eng_start),
    .eng_done  (eng_done),
    .eng_result(eng_result),
    .led1      (led1),
    .led2      (led2),
    .led3      (led3),
    .beep      (beep),
    .timeout   (timeout)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    if (obs !== expd) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expd, $time);
    end
  endtask

  // Reference model: edges counted since reset release; mode 0 collecting
  // samples, 1 waiting on the engine, 2 reporting the result.
  int unsigned e, win_sum, nfill, nwait, first_w, mode, cls, beep_left;
  logic [2:0]  m_led;
  logic        m_tmo;
  logic        x_valid, x_last, x_start;
  int unsigned x_data;

  // First window whose first bit arrives after the edge the model went idle.
  task automatic set_first(input int unsigned e_idle);
    first_w = 1;
    while ((first_w - 1) * W + P <= e_idle) first_w++;
  endtask

  task automatic model_step(input logic r, input logic d, input logic dn, input logic [1:0] res);
    int unsigned wsum;
    logic        win;
    x_valid = 1'b0;
    x_last  = 1'b0;
    x_start = 1'b0;
    if (r) begin
      e = 0; win_sum = 0; nfill = 0; nwait = 0; mode = 0; first_w = 1;
      m_led = '0; m_tmo = 1'b0; beep_left = 0; x_data = 0;
    end else begin
      e++;
      if (beep_left != 0) beep_left--;
      if (e % P == 0) win_sum += int'(d);
      win  = (e % W == 0);
      wsum = win_sum;
      if (win) win_sum = 0;
      case (mode)
        0: begin
          if (win && (e / W) >= first_w) begin
            x_valid = 1'b1;
            x_data  = wsum;
            nfill++;
            if (nfill == FRAME) begin
              x_last = 1'b1; x_start = 1'b1; mode = 1; nwait = 0; nfill = 0;
            end
          end
        end
        1: begin
          if (dn) begin
            cls  = int'(res);
            mode = 2;
          end else if (win) begin
            nwait++;
            if (nwait == TIMEOUT) begin
              m_tmo = 1'b1;
              mode  = 0;
              set_first(e);
            end
          end
        end
        default: begin
          m_led = (cls == 0) ? 3'd0 : 3'(1 << (cls - 1));
          if (cls == 3) beep_left = BEEP_CYC;
          mode = 0;
          set_first(e);
        end
      endcase
    end
  endtask

  int unsigned frame_no, plan, target, rst_left, n;
  logic [1:0]  plan_res;
  logic        did_mid;
  logic        r_v, d_v, dn_v;
  logic [1:0]  res_v;

  initial begin
    frame_no = 0; plan = 1; target = 0; rst_left = 3; did_mid = 1'b0; plan_res = '0;
    rst = 1'b1; dat_i = 1'b0; eng_done = 1'b0; eng_result = '0;
    model_step(1'b1, 1'b0, 1'b0, 2'd0);
    for (int cyc = 1; cyc <= NCYC; cyc++) begin
      @(negedge clk);
      check("sclk", 32'(sclk), 32'((e / CLK_DIV) % 2));
      check("smp_valid", 32'(smp_valid), 32'(x_valid));
      if (x_valid) check("smp_data", 32'(smp_data), x_data);
      check("frm_last", 32'(frm_last), 32'(x_last));
      check("eng_start", 32'(eng_start), 32'(x_start));
      check("leds", 32'({led3, led2, led1}), 32'(m_led));
      check("beep", 32'(beep), 32'(beep_left != 0));
      check("timeout", 32'(timeout), 32'(m_tmo));

      // Abort once in the middle of a frame.
      if (!did_mid && frame_no >= 4 && mode == 0 && nfill == 3) begin
        did_mid  = 1'b1;
        rst_left = 2;
      end
      r_v = (rst_left != 0);
      if (rst_left != 0) rst_left--;

      n = e / P + 1;
      case (frame_no % 4)
        0:       d_v = 1'b1;
        1:       d_v = n[0];
        2:       d_v = 1'($urandom_range(0, 1));
        default: d_v = 1'b0;
      endcase

      if (mode == 1) begin
        dn_v  = (plan != 1) && (e + 1 == target);
        res_v = plan_res;
      end else begin
        dn_v  = ($urandom_range(0, 39) == 0);
        res_v = 2'($urandom_range(0, 3));
      end

      rst = r_v; dat_i = d_v; eng_done = dn_v; eng_result = res_v;
      model_step(r_v, d_v, dn_v, res_v);

      // Script the engine reply for the frame just handed over.
      if (x_start) begin
        frame_no++;
        case (frame_no)
          1:       begin plan = 0; plan_res = 2'd3; end
          2:       begin plan = 1; plan_res = 2'd2; end
          3:       begin plan = 2; plan_res = 2'd1; end
          default: begin plan = $urandom_range(0, 2); plan_res = 2'($urandom_range(0, 3)); end
        endcase
        target = (plan == 2) ? e + TIMEOUT * W : e + $urandom_range(1, TIMEOUT * W - 1);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
